// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared widths, bit positions and bubble constants for the
// control-bundle pipeline (ctrl_pipe) fed by the ID-stage decoder.
package ctrl_pkg;

  localparam int W_EXE = 5;   // EX-stage control bundle
  localparam int W_MEM = 3;   // MEM-stage control bundle
  localparam int W_WB  = 2;   // WB-stage control bundle
  localparam int W_PW  = 6;   // ALU op code forwarded to EX

  // Bit positions inside the MEM and WB bundles
  localparam int MEM_RD_BIT  = W_MEM - 1;
  localparam int MEM_WR_BIT  = W_MEM - 2;
  localparam int REG_WR_BIT  = W_WB - 1;
  localparam int MEM2REG_BIT = W_WB - 2;

  // A bubble carries no controls at all, so nothing downstream can write
  localparam logic [W_EXE-1:0] BUBBLE_EXE = '0;
  localparam logic [W_MEM-1:0] BUBBLE_MEM = '0;
  localparam logic [W_WB-1:0]  BUBBLE_WB  = '0;
  localparam logic [W_PW-1:0]  BUBBLE_PW  = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decoder-side inputs, pipeline control and per-stage outputs
// of ctrl_pipe.
//   master : drives decoder bundles, id_valid, hold, stall_id, flush_ex;
//            observes the EX/MEM/WB outputs, ex_mem_rd and bubble_cnt
//   slave  : the pipeline itself
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [W_EXE-1:0] ctrl_EXE;
  logic [W_MEM-1:0] ctrl_MEM;
  logic [W_WB-1:0]  ctrl_WB;
  logic [W_PW-1:0]  codigopw;
  logic             id_valid;
  logic             hold;
  logic             stall_id;
  logic             flush_ex;

  logic [W_EXE-1:0] ex_ctrl_EXE;
  logic [W_PW-1:0]  ex_codigopw;
  logic             ex_valid;
  logic [W_MEM-1:0] mem_ctrl_MEM;
  logic             mem_valid;
  logic [W_WB-1:0]  wb_ctrl_WB;
  logic             wb_valid;
  logic             ex_mem_rd;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output ctrl_EXE, ctrl_MEM, ctrl_WB, codigopw, id_valid, hold, stall_id, flush_ex,
    input  ex_ctrl_EXE, ex_codigopw, ex_valid, mem_ctrl_MEM, mem_valid,
           wb_ctrl_WB, wb_valid, ex_mem_rd, bubble_cnt
  );

  modport slave (
    input  ctrl_EXE, ctrl_MEM, ctrl_WB, codigopw, id_valid, hold, stall_id, flush_ex,
    output ex_ctrl_EXE, ex_codigopw, ex_valid, mem_ctrl_MEM, mem_valid,
           wb_ctrl_WB, wb_valid, ex_mem_rd, bubble_cnt
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline register holding a control bundle plus valid.
//   clk, rst_n : clock, async active-low reset (clears bundle and valid)
//   d, valid_in: bundle and valid from the previous stage
//   load_en    : stage advances this edge (low = hold)
//   bubble     : load an empty slot instead of d
//   q, valid   : registered bundle and valid
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         valid_in,
  input  logic         load_en,
  input  logic         bubble,
  output logic [W-1:0] q,
  output logic         valid
);

  // An invalid slot is always stored with all-zero controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load_en) begin
      if (bubble || !valid_in) begin
        q     <= '0;
        valid <= 1'b0;
      end else begin
        q     <= d;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoder control bundles through EX, MEM and WB with
// global hold, EX flush and load-use bubble insertion.
//   clk, rst_n : clock, async active-low reset
//   bus        : ctrl_pipe_if.slave (decoder inputs, pipe control, stage outputs)
// Optional build macro CTRL_PIPE_STATS_EN enables the saturating bubble
// counter; without it bubble_cnt is constant 0.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave bus
);

  localparam int W_EX_ST  = W_EXE + W_PW + W_MEM + W_WB;
  localparam int W_MEM_ST = W_MEM + W_WB;

  logic [W_EX_ST-1:0]  ex_q;
  logic [W_MEM_ST-1:0] mem_q;
  logic [W_WB-1:0]     wb_q;
  logic [W_MEM-1:0]    ex_mem;
  logic [W_WB-1:0]     ex_wb;
  logic [W_WB-1:0]     mem_wb;
  logic                ex_valid;
  logic                mem_valid;
  logic                wb_valid;
  logic                advance;

  assign advance = !bus.hold;

  // flush_ex and stall_id both just turn the EX load into a bubble
  ctrl_stage_reg #(.W(W_EX_ST)) u_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        ({bus.ctrl_EXE, bus.codigopw, bus.ctrl_MEM, bus.ctrl_WB}),
    .valid_in (bus.id_valid),
    .load_en  (advance),
    .bubble   (bus.flush_ex || bus.stall_id),
    .q        (ex_q),
    .valid    (ex_valid)
  );

  assign {bus.ex_ctrl_EXE, bus.ex_codigopw, ex_mem, ex_wb} = ex_q;

  ctrl_stage_reg #(.W(W_MEM_ST)) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        ({ex_mem, ex_wb}),
    .valid_in (ex_valid),
    .load_en  (advance),
    .bubble   (1'b0),
    .q        (mem_q),
    .valid    (mem_valid)
  );

  assign {bus.mem_ctrl_MEM, mem_wb} = mem_q;

  ctrl_stage_reg #(.W(W_WB)) u_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (mem_wb),
    .valid_in (mem_valid),
    .load_en  (advance),
    .bubble   (1'b0),
    .q        (wb_q),
    .valid    (wb_valid)
  );

  assign bus.wb_ctrl_WB = wb_q;
  assign bus.ex_valid   = ex_valid;
  assign bus.mem_valid  = mem_valid;
  assign bus.wb_valid   = wb_valid;
  assign bus.ex_mem_rd  = ex_valid && ex_mem[MEM_RD_BIT];

`ifdef CTRL_PIPE_STATS_EN
  logic             ex_bubble;
  logic [CNT_W-1:0] cnt;

  assign ex_bubble = advance && (bus.flush_ex || bus.stall_id || !bus.id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ex_bubble && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.bubble_cnt = cnt;
`else
  assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [CNT_W-1:0] exp_cnt;
  logic [CNT_W-1:0] cnt_before;

  ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();

  ctrl_pipe #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected bubble counter: saturating count of non-hold EX bubbles
  task automatic tick();
`ifdef CTRL_PIPE_STATS_EN
    if (rst_n && !bus.hold && (bus.flush_ex || bus.stall_id || !bus.id_valid)
        && exp_cnt != '1)
      exp_cnt = exp_cnt + 1'b1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] exe, input logic [2:0] mem, input logic [1:0] wb,
                       input logic [5:0] pw, input logic v);
    bus.ctrl_EXE = exe;
    bus.ctrl_MEM = mem;
    bus.ctrl_WB  = wb;
    bus.codigopw = pw;
    bus.id_valid = v;
  endtask

  task automatic chk_stages(input string tag, input logic [4:0] exe, input logic [5:0] pw,
                            input logic exv, input logic [2:0] mem, input logic memv,
                            input logic [1:0] wb, input logic wbv);
    chk({tag, ".ex_ctrl_EXE"},  bus.ex_ctrl_EXE,  exe);
    chk({tag, ".ex_codigopw"},  bus.ex_codigopw,  pw);
    chk({tag, ".ex_valid"},     bus.ex_valid,     exv);
    chk({tag, ".mem_ctrl_MEM"}, bus.mem_ctrl_MEM, mem);
    chk({tag, ".mem_valid"},    bus.mem_valid,    memv);
    chk({tag, ".wb_ctrl_WB"},   bus.wb_ctrl_WB,   wb);
    chk({tag, ".wb_valid"},     bus.wb_valid,     wbv);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = '0;
    rst_n    = 1'b0;
    bus.hold = 1'b0;
    bus.stall_id = 1'b0;
    bus.flush_ex = 1'b0;
    drive(5'h1F, 3'h7, 2'h3, 6'h3F, 1'b1);
    #12;
    chk_stages("rst0", 5'h0, 6'h0, 1'b0, 3'h0, 1'b0, 2'h0, 1'b0);
    chk("rst0.ex_mem_rd", bus.ex_mem_rd, 1'b0);
    chk("rst0.bubble_cnt", bus.bubble_cnt, 4'h0);

    // Fill the pipe with the all-ones bundle, then reset mid-cycle
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel.ex_ctrl_EXE", bus.ex_ctrl_EXE, 5'h1F);
    chk("rel.ex_mem_rd", bus.ex_mem_rd, 1'b1);
    tick();
    tick();
    chk_stages("full", 5'h1F, 6'h3F, 1'b1, 3'h7, 1'b1, 2'h3, 1'b1);
    #4;
    rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    chk_stages("rst_mid", 5'h0, 6'h0, 1'b0, 3'h0, 1'b0, 2'h0, 1'b0);
    chk("rst_mid.ex_mem_rd", bus.ex_mem_rd, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_stages("rel2", 5'h1F, 6'h3F, 1'b1, 3'h0, 1'b0, 2'h0, 1'b0);

    // add then sub
    drive(5'h00, 3'h0, 2'b10, 6'h20, 1'b1);
    tick();
    chk("flow.e1.pw", bus.ex_codigopw, 6'h20);
    drive(5'h00, 3'h0, 2'b10, 6'h22, 1'b1);
    tick();
    chk("flow.e2.pw", bus.ex_codigopw, 6'h22);
    chk("flow.e2.wb", bus.wb_ctrl_WB, 2'h3);
    drive(5'h1F, 3'h7, 2'h3, 6'h3F, 1'b0);
    tick();
    chk_stages("flow.e3", 5'h0, 6'h0, 1'b0, 3'h0, 1'b1, 2'b10, 1'b1);
    tick();
    chk("flow.e4.wb", bus.wb_ctrl_WB, 2'b10);
    chk("flow.e4.wbv", bus.wb_valid, 1'b1);
    chk("flow.cnt", bus.bubble_cnt, exp_cnt);

    // Load-use: lw in EX, stall one edge
    drive(5'h03, 3'b100, 2'b11, 6'h23, 1'b1);
    tick();
    chk("lu.ex_mem_rd", bus.ex_mem_rd, 1'b1);
    cnt_before = bus.bubble_cnt;
    bus.stall_id = 1'b1;
    tick();
    chk_stages("lu.stall", 5'h0, 6'h0, 1'b0, 3'b100, 1'b1, 2'h0, 1'b0);
    chk("lu.ex_mem_rd0", bus.ex_mem_rd, 1'b0);
`ifdef CTRL_PIPE_STATS_EN
    chk("lu.cnt_inc", bus.bubble_cnt, cnt_before + 1'b1);
`else
    chk("lu.cnt_zero", bus.bubble_cnt, 4'h0);
`endif
    bus.stall_id = 1'b0;
    tick();
    chk_stages("lu.redo", 5'h03, 6'h23, 1'b1, 3'h0, 1'b0, 2'b11, 1'b1);

    // Fill with A, B, C then hold with stall and flush asserted
    drive(5'h0A, 3'b001, 2'b01, 6'h11, 1'b1);
    tick();
    drive(5'h0B, 3'b010, 2'b10, 6'h12, 1'b1);
    tick();
    drive(5'h0C, 3'b100, 2'b11, 6'h13, 1'b1);
    tick();
    chk_stages("hold.pre", 5'h0C, 6'h13, 1'b1, 3'b010, 1'b1, 2'b01, 1'b1);
    cnt_before = bus.bubble_cnt;
    drive(5'h0D, 3'b000, 2'b00, 6'h14, 1'b1);
    bus.hold = 1'b1;
    bus.stall_id = 1'b1;
    bus.flush_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_stages("hold", 5'h0C, 6'h13, 1'b1, 3'b010, 1'b1, 2'b01, 1'b1);
      chk("hold.cnt", bus.bubble_cnt, cnt_before);
    end
    bus.hold = 1'b0;
    bus.stall_id = 1'b0;
    bus.flush_ex = 1'b0;
    tick();
    chk_stages("hold.rel", 5'h0D, 6'h14, 1'b1, 3'b100, 1'b1, 2'b10, 1'b1);

    // Flush and stall together: one bubble
    cnt_before = bus.bubble_cnt;
    bus.stall_id = 1'b1;
    bus.flush_ex = 1'b1;
    tick();
    chk_stages("fs", 5'h0, 6'h0, 1'b0, 3'b000, 1'b1, 2'b11, 1'b1);
`ifdef CTRL_PIPE_STATS_EN
    chk("fs.cnt_inc", bus.bubble_cnt, cnt_before + 1'b1);
`else
    chk("fs.cnt_zero", bus.bubble_cnt, 4'h0);
`endif
    bus.flush_ex = 1'b0;

    // 20 consecutive stalls drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      tick();
`ifndef CTRL_PIPE_STATS_EN
      chk("sat.zero", bus.bubble_cnt, 4'h0);
`endif
    end
    chk_stages("sat", 5'h0, 6'h0, 1'b0, 3'h0, 1'b0, 2'h0, 1'b0);
`ifdef CTRL_PIPE_STATS_EN
    chk("sat.cnt", bus.bubble_cnt, 4'hF);
`endif
    chk("sat.model", bus.bubble_cnt, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
